// File: rtl/tt_sweep_capture_pkg.sv
// Shared definitions for the truth-table sweeper: state encoding, default
// input count, table-width derivation and the deepest supported function pipeline.
package tt_sweep_capture_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } tt_state_e;

    localparam int TT_N_IN_DEFAULT = 7;
    localparam int TT_EVAL_LAT_MAX = 4;

    function automatic int tt_width(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/tt_sweep_capture_if.sv
// Bus between the sweeper, the function under evaluation and the downstream
// classifier: minterm drive, function response and the table handshake.
interface tt_sweep_capture_if
    import tt_sweep_capture_pkg::*;
#(
    parameter int N_IN = TT_N_IN_DEFAULT
);
    localparam int TT_W = tt_width(N_IN);

    logic [N_IN-1:0] eval_x;
    logic            eval_en;
    logic            eval_out;
    logic [TT_W-1:0] tt;
    logic            tt_valid;
    logic            tt_ready;
    logic [N_IN:0]   tt_ones;

    modport master (
        output eval_x, eval_en, tt, tt_valid, tt_ones,
        input  eval_out, tt_ready
    );

    modport slave (
        input  eval_x, eval_en, tt, tt_valid, tt_ones,
        output eval_out, tt_ready
    );
endinterface

// File: rtl/tt_sweep_delay.sv
// Shift register of configurable depth carrying {enable, minterm} alongside the
// evaluated function's pipeline; flush empties every stage. Depth 0 is a plain wire.
module tt_sweep_delay #(
    parameter int W     = 8,
    parameter int DEPTH = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    genvar gi;

    generate
        if (DEPTH == 0) begin : g_wire
            // No storage: the caller masks captures during flush itself.
            logic unused_ok;
            assign unused_ok = &{1'b0, clk, rst_n, flush};
            assign dout = din;
        end else begin : g_shift
            for (gi = 0; gi < DEPTH; gi++) begin : g_stage
                logic [W-1:0] q_reg;
                logic [W-1:0] d_next;

                if (gi == 0) begin : g_head
                    assign d_next = din;
                end else begin : g_tail
                    assign d_next = g_stage[gi-1].q_reg;
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        q_reg <= '0;
                    end else if (flush) begin
                        q_reg <= '0;
                    end else begin
                        q_reg <= d_next;
                    end
                end
            end
            assign dout = g_stage[DEPTH-1].q_reg;
        end
    endgenerate

endmodule

// File: rtl/tt_sweep_capture.sv
// Exhaustive truth-table sweeper: drives every minterm into the function under
// evaluation, packs the responses into tt and offers it over valid/ready.
// Optional running popcount on tt_ones: TT_SWEEP_CAPTURE_POPCOUNT_EN.
module tt_sweep_capture
    import tt_sweep_capture_pkg::*;
#(
    parameter int N_IN     = TT_N_IN_DEFAULT,
    parameter int EVAL_LAT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    output logic busy,
    tt_sweep_capture_if.master bus
);
    localparam int TT_W       = tt_width(N_IN);
    localparam int IW         = N_IN + 1;
    localparam int DW         = $clog2(TT_EVAL_LAT_MAX + 1);
    localparam int DRAIN_LAST = (EVAL_LAT > 0) ? EVAL_LAT - 1 : 0;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SWEEP = SWEEP;
    localparam logic [1:0] ST_DRAIN = DRAIN;
    localparam logic [1:0] ST_HOLD  = HOLD;

    logic [1:0]      state_reg, state_next;
    logic [IW-1:0]   idx_reg, idx_next;
    logic [DW-1:0]   drain_reg, drain_next;
    logic [TT_W-1:0] tt_reg;

    logic            live;
    logic            flush;
    logic            launch;
    logic            last_idx;
    logic            cap_en;
    logic [N_IN-1:0] cap_idx;
    logic            capture;

    assign live     = (state_reg == ST_SWEEP);
    assign flush    = abort && (state_reg != ST_IDLE);
    assign launch   = (state_reg == ST_IDLE) && start && !abort;
    assign last_idx = (idx_reg == IW'(TT_W - 1));

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        drain_next = drain_reg;
        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (launch) begin
                        state_next = ST_SWEEP;
                        idx_next   = '0;
                    end
                end
                ST_SWEEP: begin
                    idx_next = idx_reg + IW'(1);
                    if (last_idx) begin
                        drain_next = '0;
                        state_next = (EVAL_LAT > 0) ? ST_DRAIN : ST_HOLD;
                    end
                end
                ST_DRAIN: begin
                    drain_next = drain_reg + DW'(1);
                    if (drain_reg == DW'(DRAIN_LAST)) begin
                        state_next = ST_HOLD;
                    end
                end
                default: begin
                    if (bus.tt_ready) begin
                        state_next = ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            drain_reg <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            drain_reg <= drain_next;
        end
    end

    // Enable and minterm travel with the function's pipeline so each response
    // lands in the bit of the minterm that produced it.
    tt_sweep_delay #(
        .W     (N_IN + 1),
        .DEPTH (EVAL_LAT)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .din   ({live, idx_reg[N_IN-1:0]}),
        .dout  ({cap_en, cap_idx})
    );

    assign capture = cap_en && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt_reg <= '0;
        end else if (launch) begin
            tt_reg <= '0;
        end else if (capture) begin
            tt_reg[cap_idx] <= bus.eval_out;
        end
    end

`ifdef TT_SWEEP_CAPTURE_POPCOUNT_EN
    logic [N_IN:0] ones_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_reg <= '0;
        end else if (launch) begin
            ones_reg <= '0;
        end else if (capture && bus.eval_out) begin
            ones_reg <= ones_reg + (N_IN + 1)'(1);
        end
    end

    assign bus.tt_ones = ones_reg;
`else
    assign bus.tt_ones = '0;
`endif

    assign bus.eval_x   = live ? idx_reg[N_IN-1:0] : '0;
    assign bus.eval_en  = live;
    assign bus.tt       = tt_reg;
    assign bus.tt_valid = (state_reg == ST_HOLD);
    assign busy         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Directed bench for tt_sweep_capture: a zero-latency instance with selectable
// functions and a two-cycle-latency instance evaluating x6.
module tb_tt_sweep_capture;
    import tt_sweep_capture_pkg::*;

`ifdef TT_SWEEP_CAPTURE_POPCOUNT_EN
    localparam bit POP = 1'b1;
`else
    localparam bit POP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start0, abort0, busy0;
    logic start2, abort2, busy2;

    tt_sweep_capture_if #(.N_IN(7)) bus0 ();
    tt_sweep_capture_if #(.N_IN(7)) bus2 ();

    tt_sweep_capture #(.N_IN(7), .EVAL_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .busy(busy0), .bus(bus0)
    );
    tt_sweep_capture #(.N_IN(7), .EVAL_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .busy(busy2), .bus(bus2)
    );

    // Zero-latency function select: 0 = x0, 1 = const 0, 2 = const 1, 3 = majority table
    logic [1:0]   fsel;
    logic [127:0] maj_tt = 128'hfeeaeee0fcc8ecc0fcc8ecc0f888a880;
    logic         f0;
    always_comb begin
        f0 = 1'b0;
        case (fsel)
            2'd0: f0 = bus0.eval_x[0];
            2'd1: f0 = 1'b0;
            2'd2: f0 = 1'b1;
            default: f0 = maj_tt[bus0.eval_x];
        endcase
    end
    assign bus0.eval_out = f0;

    // x6 through a two-stage pipeline
    logic p1, p2;
    always_ff @(posedge clk) begin
        p1 <= bus2.eval_x[6];
        p2 <= p1;
    end
    assign bus2.eval_out = p2;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] TT_X0   = {64{2'b10}};
    localparam logic [127:0] TT_X6   = {{64{1'b1}}, {64{1'b0}}};
    localparam logic [127:0] TT_ONES = {128{1'b1}};

    // Pulse start on dut0, count edges until tt_valid, sample minterm drive at edge 5.
    task automatic run0(output int edges, output logic [6:0] x5, output logic en5);
        @(negedge clk) start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        edges = 0; x5 = '0; en5 = 1'b0;
        while (edges < 400) begin
            @(posedge clk);
            edges++;
            #1;
            if (edges == 5) begin x5 = bus0.eval_x; en5 = bus0.eval_en; end
            if (bus0.tt_valid) break;
        end
    endtask

    task automatic run2(output int edges, output logic en129);
        @(negedge clk) start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        edges = 0; en129 = 1'b1;
        while (edges < 400) begin
            @(posedge clk);
            edges++;
            #1;
            if (edges == 129) en129 = bus2.eval_en;
            if (bus2.tt_valid) break;
        end
    endtask

    task automatic accept0();
        @(negedge clk) bus0.tt_ready = 1'b1;
        @(posedge clk);
        #1 bus0.tt_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start0 = 1'b0; abort0 = 1'b0; start2 = 1'b0; abort2 = 1'b0;
        bus0.tt_ready = 1'b0; bus2.tt_ready = 1'b0; fsel = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus0.eval_x !== 7'd0) begin n_fail++; $display("FAIL reset_eval_x: got %0d want 0", bus0.eval_x); end
        n_checks++; if (bus0.eval_en !== 1'b0) begin n_fail++; $display("FAIL reset_eval_en: got %b want 0", bus0.eval_en); end
        n_checks++; if (busy0 !== 1'b0 || busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b/%b want 0/0", busy0, busy2); end
        n_checks++; if (bus0.tt !== 128'd0) begin n_fail++; $display("FAIL reset_tt: got %h want 0", bus0.tt); end
        n_checks++; if (bus0.tt_valid !== 1'b0 || bus2.tt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tt_valid: got %b/%b want 0/0", bus0.tt_valid, bus2.tt_valid); end
        n_checks++; if (bus0.tt_ones !== 8'd0) begin n_fail++; $display("FAIL reset_tt_ones: got %0d want 0", bus0.tt_ones); end
        @(negedge clk) rst_n = 1'b1;
        $display("reset: released");
    endtask

    task automatic test_x0();
        int edges; logic [6:0] x5; logic en5;
        fsel = 2'd0;
        run0(edges, x5, en5);
        n_checks++; if (edges !== 128) begin n_fail++; $display("FAIL x0_valid_edge: got %0d want 128", edges); end
        n_checks++; if (x5 !== 7'd5 || en5 !== 1'b1) begin n_fail++; $display("FAIL x0_drive_edge5: got x=%0d en=%b want x=5 en=1", x5, en5); end
        n_checks++; if (bus0.tt !== TT_X0) begin n_fail++; $display("FAIL x0_tt: got %h want %h", bus0.tt, TT_X0); end
        n_checks++; if (bus0.tt_ones !== (POP ? 8'd64 : 8'd0)) begin n_fail++; $display("FAIL x0_ones: got %0d want %0d", bus0.tt_ones, POP ? 64 : 0); end
        accept0();
        n_checks++; if (bus0.tt_valid !== 1'b0 || busy0 !== 1'b0) begin n_fail++; $display("FAIL x0_accept: got valid=%b busy=%b want 0/0", bus0.tt_valid, busy0); end
        n_checks++; if (bus0.tt !== TT_X0) begin n_fail++; $display("FAIL x0_tt_kept: got %h want %h", bus0.tt, TT_X0); end
        $display("x0: valid at edge %0d tt=%h ones=%0d", edges, bus0.tt, bus0.tt_ones);
    endtask

    task automatic test_lat2();
        int edges; logic en129;
        run2(edges, en129);
        n_checks++; if (edges !== 130) begin n_fail++; $display("FAIL lat2_valid_edge: got %0d want 130", edges); end
        n_checks++; if (en129 !== 1'b0) begin n_fail++; $display("FAIL lat2_drain_en: got %b want 0", en129); end
        n_checks++; if (bus2.tt !== TT_X6) begin n_fail++; $display("FAIL lat2_tt: got %h want %h", bus2.tt, TT_X6); end
        n_checks++; if (bus2.tt_ones !== (POP ? 8'd64 : 8'd0)) begin n_fail++; $display("FAIL lat2_ones: got %0d want %0d", bus2.tt_ones, POP ? 64 : 0); end
        @(negedge clk) bus2.tt_ready = 1'b1;
        @(posedge clk);
        #1 bus2.tt_ready = 1'b0;
        n_checks++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL lat2_accept_busy: got %b want 0", busy2); end
        $display("lat2: valid at edge %0d tt=%h ones=%0d", edges, bus2.tt, bus2.tt_ones);
    endtask

    task automatic test_majority();
        int edges; logic [6:0] x5; logic en5;
        fsel = 2'd3;
        run0(edges, x5, en5);
        n_checks++; if (bus0.tt !== 128'hfeeaeee0fcc8ecc0fcc8ecc0f888a880) begin n_fail++; $display("FAIL maj_tt: got %h want feeaeee0fcc8ecc0fcc8ecc0f888a880", bus0.tt); end
        n_checks++; if (bus0.tt_ones !== (POP ? 8'($countones(maj_tt)) : 8'd0)) begin n_fail++; $display("FAIL maj_ones: got %0d want %0d", bus0.tt_ones, POP ? $countones(maj_tt) : 0); end
        accept0();
        $display("majority: tt=%h", bus0.tt);
    endtask

    task automatic test_backpressure();
        int edges; logic [6:0] x5; logic en5;
        fsel = 2'd2;
        run0(edges, x5, en5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk) start0 = (i == 3);
            @(posedge clk);
            #1;
            n_checks++; if (bus0.tt_valid !== 1'b1 || busy0 !== 1'b1) begin n_fail++; $display("FAIL bp_hold_%0d: got valid=%b busy=%b want 1/1", i, bus0.tt_valid, busy0); end
            n_checks++; if (bus0.tt !== TT_ONES) begin n_fail++; $display("FAIL bp_tt_%0d: got %h want all ones", i, bus0.tt); end
        end
        n_checks++; if (bus0.tt_ones !== (POP ? 8'd128 : 8'd0)) begin n_fail++; $display("FAIL const1_ones: got %0d want %0d", bus0.tt_ones, POP ? 128 : 0); end
        // start coincident with the accepting edge must be dropped
        @(negedge clk) begin bus0.tt_ready = 1'b1; start0 = 1'b1; end
        @(posedge clk);
        #1 begin bus0.tt_ready = 1'b0; start0 = 1'b0; end
        n_checks++; if (busy0 !== 1'b0 || bus0.tt_valid !== 1'b0) begin n_fail++; $display("FAIL bp_accept: got busy=%b valid=%b want 0/0", busy0, bus0.tt_valid); end
        @(posedge clk);
        #1;
        n_checks++; if (busy0 !== 1'b0 || bus0.eval_en !== 1'b0) begin n_fail++; $display("FAIL bp_no_restart: got busy=%b en=%b want 0/0", busy0, bus0.eval_en); end
        n_checks++; if (bus0.tt !== TT_ONES) begin n_fail++; $display("FAIL bp_tt_after_accept: got %h want all ones", bus0.tt); end
        $display("backpressure: held 10 cycles, accepted");
    endtask

    task automatic test_const0();
        int edges; logic [6:0] x5; logic en5;
        fsel = 2'd1;
        run0(edges, x5, en5);
        n_checks++; if (bus0.tt !== 128'd0) begin n_fail++; $display("FAIL const0_tt: got %h want 0", bus0.tt); end
        n_checks++; if (bus0.tt_ones !== 8'd0) begin n_fail++; $display("FAIL const0_ones: got %0d want 0", bus0.tt_ones); end
        accept0();
        $display("const0: tt=%h ones=%0d", bus0.tt, bus0.tt_ones);
    endtask

    task automatic test_abort();
        int edges; int seen; logic [6:0] x5; logic en5;
        fsel = 2'd0;
        @(negedge clk) start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        n_checks++; if (bus0.eval_x !== 7'd50) begin n_fail++; $display("FAIL abort_at_idx: got %0d want 50", bus0.eval_x); end
        abort0 = 1'b1;
        @(posedge clk);
        #1 abort0 = 1'b0;
        n_checks++; if (busy0 !== 1'b0 || bus0.eval_en !== 1'b0 || bus0.tt_valid !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got busy=%b en=%b valid=%b want 0/0/0", busy0, bus0.eval_en, bus0.tt_valid); end
        seen = 0;
        repeat (200) begin @(posedge clk); #1; if (bus0.tt_valid) seen++; end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_valid: got %0d valid cycles want 0", seen); end
        run0(edges, x5, en5);
        n_checks++; if (edges !== 128 || bus0.tt !== TT_X0) begin n_fail++; $display("FAIL abort_resweep: got edge=%0d tt=%h want 128 %h", edges, bus0.tt, TT_X0); end
        accept0();
        $display("abort: idle after idx 50, resweep tt=%h", bus0.tt);
    endtask

    initial begin
        test_reset();
        test_x0();
        test_lat2();
        test_majority();
        test_backpressure();
        test_const0();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
